// File: rtl/mult_ctrl_if.sv
// mult_ctrl_if: operand switches, button pulses and result bus of the
// sequential multiplier controller. The master side drives switches and
// buttons; the slave side (mult_ctrl) returns operands, product and status.
interface mult_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   sw;
    logic               btn_load_a;
    logic               btn_load_b;
    logic               btn_start;
    logic               btn_clear;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [2*WIDTH-1:0] product;
    logic               busy;
    logic               done;

    modport master (
        output sw, btn_load_a, btn_load_b, btn_start, btn_clear,
        input  op_a, op_b, product, busy, done
    );

    modport slave (
        input  sw, btn_load_a, btn_load_b, btn_start, btn_clear,
        output op_a, op_b, product, busy, done
    );
endinterface

// File: rtl/mult_ctrl.sv
// mult_ctrl: button-driven sequencing controller for a shift-add multiplier.
// Captures two WIDTH-bit operands from the switches, multiplies them one
// multiplier bit per cycle (exactly WIDTH cycles) and holds the product.
// Button priority: clear > start > load_a > load_b.
// Optional feature: define MULT_CTRL_SIGNED_EN for two's complement operands
// and product (magnitudes are multiplied, result negated on sign mismatch).
module mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    mult_ctrl_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q,   state_d;
    logic [WIDTH-1:0]   op_a_q,    op_a_d;
    logic [WIDTH-1:0]   op_b_q,    op_b_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [WIDTH-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]   mplier_q,  mplier_d;
    logic [2*WIDTH-1:0] acc_q,     acc_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] acc_step_s;
    logic [2*WIDTH-1:0] result_s;
    logic [WIDTH-1:0]   start_mcand_s;
    logic [WIDTH-1:0]   start_mplier_s;

`ifdef MULT_CTRL_SIGNED_EN
    logic               neg_q, neg_d;

    // Unsigned magnitude of a two's complement value; the most negative
    // value maps onto itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction
`endif

    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier bit is set (carry kept), then shift {carry, acc} right by one.
    always_comb begin
        sum_s      = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
        acc_step_s = (2*WIDTH)'({sum_s, acc_q[WIDTH-1:0]} >> 1);
`ifdef MULT_CTRL_SIGNED_EN
        start_mcand_s  = mag_f(op_a_q);
        start_mplier_s = mag_f(op_b_q);
        if (neg_q) begin
            result_s = ~acc_step_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            result_s = acc_step_s;
        end
`else
        start_mcand_s  = op_a_q;
        start_mplier_s = op_b_q;
        result_s       = acc_step_s;
`endif
    end

    // Next-state and register-update logic for the controller FSM.
    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        product_d = product_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
`ifdef MULT_CTRL_SIGNED_EN
        neg_d     = neg_q;
`endif
        if (bus.btn_clear) begin
            state_d   = S_IDLE;
            op_a_d    = {WIDTH{1'b0}};
            op_b_d    = {WIDTH{1'b0}};
            product_d = {(2*WIDTH){1'b0}};
            mcand_d   = {WIDTH{1'b0}};
            mplier_d  = {WIDTH{1'b0}};
            acc_d     = {(2*WIDTH){1'b0}};
            cnt_d     = {CW{1'b0}};
`ifdef MULT_CTRL_SIGNED_EN
            neg_d     = 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.btn_start) begin
                        state_d  = S_RUN;
                        mcand_d  = start_mcand_s;
                        mplier_d = start_mplier_s;
                        acc_d    = {(2*WIDTH){1'b0}};
                        cnt_d    = {CW{1'b0}};
`ifdef MULT_CTRL_SIGNED_EN
                        neg_d    = op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1];
`endif
                    end else if (bus.btn_load_a) begin
                        state_d = S_IDLE;
                        op_a_d  = bus.sw;
                    end else if (bus.btn_load_b) begin
                        state_d = S_IDLE;
                        op_b_d  = bus.sw;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_RUN: begin
                    acc_d    = acc_step_s;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_LAST) begin
                        state_d   = S_DONE;
                        product_d = result_s;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            op_a_q    <= {WIDTH{1'b0}};
            op_b_q    <= {WIDTH{1'b0}};
            product_q <= {(2*WIDTH){1'b0}};
            mcand_q   <= {WIDTH{1'b0}};
            mplier_q  <= {WIDTH{1'b0}};
            acc_q     <= {(2*WIDTH){1'b0}};
            cnt_q     <= {CW{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MULT_CTRL_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            product_q <= product_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MULT_CTRL_SIGNED_EN
            neg_q     <= neg_d;
`endif
        end
    end

    assign bus.op_a    = op_a_q;
    assign bus.op_b    = op_b_q;
    assign bus.product = product_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule
